idu_multilane_pipebuf: RTL and testbench
========================================

// Module: idu_multilane_pipebuf
// PURPOSE
//  Parametrised successor of the single-lane decode-stage pipeline register, placed between the decoder(s) and the IRU.
//  Accepts up to LANES decoded instructions per cycle as opaque PAYLOAD_W-bit bundles.
//  Buffers them in an in-order circular skid queue of DEPTH entries.
//  Presents up to LANES oldest entries per cycle to the IRU, which consumes 0..LANES of them from lane 0 upward.
//  A flush from intwb discards all buffered entries.
// PARAMETERS
//  LANES      2    decode/rename width; also max enqueue and dequeue per cycle (>=1)
//  PAYLOAD_W  160  width of one decoded bundle (instr, pc, lregs, imm, ctrl fields)
//  DEPTH      8    queue entries; power of 2, DEPTH >= 2*LANES
//  CNT_W      $clog2(DEPTH+1)  derived; occupancy counter width
// PORTS
//  clock         in   1                clock
//  reset         in   1                synchronous reset, active-high
//  flush_valid   in   1                pipeline flush from intwb
//  in_valid      in   LANES            per-lane valid from decoder; contiguous from lane 0
//  in_payload    in   LANES*PAYLOAD_W  lane i at [i*PAYLOAD_W +: PAYLOAD_W]
//  in_ready      out  1                whole group may be accepted this cycle (drives ibuffer read enable)
//  out_valid     out  LANES            lane i holds the (i+1)-th oldest entry
//  out_payload   out  LANES*PAYLOAD_W  queue entries head+0..head+LANES-1
//  out_deq_cnt   in   $clog2(LANES+1)  number of lanes the IRU consumes this cycle
//  occupancy     out  CNT_W            registered entry count
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  State: mem[DEPTH] (not reset), head, tail (log2 DEPTH bits, wrap mod DEPTH), count (CNT_W).
//  Reset: head=tail=count=0 on the next edge; occupancy=0 and out_valid=0 from the cycle after reset is sampled.
//    Reset mid-operation discards contents; reset has priority over flush and all traffic.
//  Ready: in_ready = !flush_valid && (DEPTH-count) >= LANES, from registered count only.
//    No dependency on in_valid or out_deq_cnt.
//  Enqueue: enq_n = length of the contiguous valid prefix of in_valid, counted from lane 0.
//    Fires only when in_ready=1. Lane i is written to mem[(tail+i)%DEPTH]; tail += enq_n.
//    Any valid lane after the first invalid lane is dropped, and a simulation assertion fires.
//  Output: out_valid[i] = (count > i) && !flush_valid; out_payload lane i = mem[(head+i)%DEPTH].
//    out_payload is don't-care where out_valid=0.
//  Dequeue: deq_n = min(out_deq_cnt, count, LANES); head += deq_n.
//    out_deq_cnt above the number of valid lanes is clamped, and a simulation assertion fires.
//  Latency: an entry enqueued in cycle N is visible on out_valid in cycle N+1 at the earliest.
//    There is no combinational in->out bypass.
//  Simultaneous enq/deq: count_next = count + enq_n - deq_n. Full-boundary ready uses the pre-dequeue count
//    (conservative: no same-cycle space reuse).
//  Flush: when flush_valid=1, head=tail=count=0 on the next edge. Enqueue and dequeue in that cycle are ignored.
//    in_ready=0 and out_valid=0 combinationally during the flush cycle. Normal operation resumes the following cycle.
//  Wrap-around: pointers wrap modulo DEPTH. A multi-lane write or read straddling index DEPTH-1 -> 0 is legal and in order.
//  Empty: count=0 -> out_valid=0. Full: count > DEPTH-LANES -> in_ready=0.
//  occupancy = count; it never exceeds DEPTH.
// TESTING (LANES=2, PAYLOAD_W=32, DEPTH=8)
//  1. Reset with garbage inputs, release, in_valid=2'b00
//     -> in_ready=1, out_valid=0, occupancy=0 for 3 cycles.
//  2. Enqueue {0xA1,0xA0} with in_valid=2'b11 and out_deq_cnt=0
//     -> next cycle out_valid=2'b11, lane0=0xA0, lane1=0xA1, occupancy=2.
//     Then out_deq_cnt=1 -> lane0=0xA1, out_valid=2'b01.
//  3. Fill with no dequeue: 4 groups of 2
//     -> occupancy=8 and in_ready=0 from occupancy 7 onward.
//     Then dequeue 2 with enqueue 2 in one cycle -> occupancy unchanged, FIFO order preserved.
//  4. Wrap: cycle enqueue/dequeue until head=7, then read 2
//     -> lane0=mem[7], lane1=mem[0], values in insertion order.
//  5. Queue holds 5 entries; flush_valid=1 with in_valid=2'b11 and out_deq_cnt=2
//     -> same cycle in_ready=0 and out_valid=0; next cycle occupancy=0. Nothing enqueued or dequeued.
//  6. in_valid=2'b10 -> nothing enqueued and assertion fires.
//     out_deq_cnt=2 with occupancy=1 -> occupancy 0, assertion fires.

Source files
------------

// File: rtl/idu_multilane_pipebuf.sv
`default_nettype none
// ============================================================================
//  Module   : idu_multilane_pipebuf
//  Purpose  : Multi-lane decode-stage pipeline buffer sitting between the
//             decoder(s) and the IRU. Up to LANES decoded bundles enter per
//             cycle and are held in an in-order circular skid queue of DEPTH
//             entries. The LANES oldest entries are presented every cycle, and
//             the IRU consumes 0..LANES of them starting at lane 0. A flush
//             from intwb empties the queue.
//  Ports    : clock        - clock
//             reset        - synchronous reset, active-high
//             flush_valid  - pipeline flush from intwb
//             in_valid     - per-lane valid, contiguous from lane 0
//             in_payload   - lane i at [i*PAYLOAD_W +: PAYLOAD_W]
//             in_ready     - the whole input group can be taken this cycle
//             out_valid    - lane i holds the (i+1)-th oldest entry
//             out_payload  - queue entries head+0 .. head+LANES-1
//             out_deq_cnt  - number of lanes the IRU consumes this cycle
//             occupancy    - registered entry count
//  Revision : 1.0 - initial release
// ============================================================================
module idu_multilane_pipebuf #(
  parameter int LANES     = 2,
  parameter int PAYLOAD_W = 160,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush_valid,
  input  logic [LANES-1:0]             in_valid,
  input  logic [LANES*PAYLOAD_W-1:0]   in_payload,
  output logic                         in_ready,
  output logic [LANES-1:0]             out_valid,
  output logic [LANES*PAYLOAD_W-1:0]   out_payload,
  input  logic [$clog2(LANES+1)-1:0]   out_deq_cnt,
  output logic [CNT_W-1:0]             occupancy
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_DQ_W  = $clog2(LANES + 1);

  logic [PAYLOAD_W-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_head;
  logic [c_PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]     r_count;

  logic [c_DQ_W-1:0]    w_enq_n;    // contiguous valid prefix length
  logic                 w_hole;     // a valid lane follows an invalid one
  logic                 w_gap;
  logic [c_DQ_W-1:0]    w_avail;    // lanes currently presented as valid
  logic [c_DQ_W-1:0]    w_enq_acc;  // lanes actually written this cycle
  logic [c_DQ_W-1:0]    w_deq_n;    // lanes actually consumed this cycle
  logic [CNT_W-1:0]     w_free;

  // Space check uses the pre-dequeue count so ready never depends on the
  // IRU's consume decision in the same cycle.
  assign w_free    = CNT_W'(DEPTH) - r_count;
  assign in_ready  = !flush_valid && (w_free >= CNT_W'(LANES));
  assign occupancy = r_count;

  always_comb begin
    w_enq_n = '0;
    w_gap   = 1'b0;
    w_hole  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (in_valid[i]) begin
        if (w_gap) w_hole = 1'b1;
        else       w_enq_n = w_enq_n + c_DQ_W'(1);
      end else begin
        w_gap = 1'b1;
      end
    end
  end

  assign w_avail   = (r_count >= CNT_W'(LANES)) ? c_DQ_W'(LANES) : c_DQ_W'(r_count);
  assign w_enq_acc = in_ready ? w_enq_n : '0;
  // flush_valid forces out_valid to zero, so nothing may be consumed then.
  assign w_deq_n   = flush_valid ? '0 :
                     ((out_deq_cnt < w_avail) ? out_deq_cnt : w_avail);

  // Read side: pointer arithmetic wraps naturally because DEPTH is a power of 2.
  for (genvar g = 0; g < LANES; g++) begin : g_out
    assign out_valid[g] = (r_count > CNT_W'(g)) && !flush_valid;
    assign out_payload[g*PAYLOAD_W +: PAYLOAD_W] = r_mem[r_head + c_PTR_W'(g)];
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (!reset && in_ready) begin
      for (int i = 0; i < LANES; i++) begin
        if (i < int'(w_enq_n)) begin
          r_mem[r_tail + c_PTR_W'(i)] <= in_payload[i*PAYLOAD_W +: PAYLOAD_W];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush_valid) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + c_PTR_W'(w_enq_acc);
      r_head  <= r_head + c_PTR_W'(w_deq_n);
      r_count <= r_count + CNT_W'(w_enq_acc) - CNT_W'(w_deq_n);
    end
  end

  // Protocol checks on the decoder and IRU handshakes; illegal requests are
  // tolerated (dropped or clamped) and only reported.
  always_ff @(posedge clock) begin
    if (!reset && !flush_valid) begin
      assert (!w_hole)
        else $warning("idu_multilane_pipebuf: non-contiguous in_valid %b, trailing lanes dropped", in_valid);
      assert (out_deq_cnt <= w_avail)
        else $warning("idu_multilane_pipebuf: out_deq_cnt %0d exceeds valid lanes %0d, clamped", out_deq_cnt, w_avail);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_idu_multilane_pipebuf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_idu_multilane_pipebuf
//  Purpose  : Self-checking bench for idu_multilane_pipebuf (LANES=2,
//             PAYLOAD_W=32, DEPTH=8). Directed cycles carry hand-computed
//             ready/valid/occupancy values; accepted payloads are pushed to an
//             expected queue that an independent monitor compares and pops.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_idu_multilane_pipebuf;

  localparam int LANES     = 2;
  localparam int PAYLOAD_W = 32;
  localparam int DEPTH     = 8;
  localparam int CNT_W     = $clog2(DEPTH + 1);

  logic                       clock = 1'b0;
  logic                       reset;
  logic                       flush_valid;
  logic [LANES-1:0]           in_valid;
  logic [LANES*PAYLOAD_W-1:0] in_payload;
  logic                       in_ready;
  logic [LANES-1:0]           out_valid;
  logic [LANES*PAYLOAD_W-1:0] out_payload;
  logic [1:0]                 out_deq_cnt;
  logic [CNT_W-1:0]           occupancy;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  idu_multilane_pipebuf #(
    .LANES(LANES), .PAYLOAD_W(PAYLOAD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .flush_valid(flush_valid),
    .in_valid(in_valid), .in_payload(in_payload), .in_ready(in_ready),
    .out_valid(out_valid), .out_payload(out_payload),
    .out_deq_cnt(out_deq_cnt), .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented valid lane must match the expected queue in
  // order; lanes consumed this cycle are then popped.
  always @(negedge clock) begin
    if (!reset) begin
      int nvalid;
      int ndeq;
      nvalid = 0;
      for (int i = 0; i < LANES; i++) begin
        if (out_valid[i]) begin
          if (i == nvalid) nvalid++;
          if (i < exp_q.size()) begin
            chk($sformatf("lane%0d_payload", i), out_payload[i*PAYLOAD_W +: PAYLOAD_W], exp_q[i]);
          end else begin
            n_checks++;
            n_errors++;
            $display("FAIL lane%0d_extra: got valid payload %h expected no entry at %0t",
                     i, out_payload[i*PAYLOAD_W +: PAYLOAD_W], $time);
          end
        end
      end
      ndeq = (int'(out_deq_cnt) < nvalid) ? int'(out_deq_cnt) : nvalid;
      for (int k = 0; k < ndeq; k++) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  // One directed cycle: drive inputs, record accepted payloads, check the
  // pre-edge ready/valid/occupancy, then advance past the clock edge.
  task automatic cyc(input bit fl, input bit [1:0] iv, input logic [31:0] p0,
                     input logic [31:0] p1, input bit [1:0] dq, input int acc,
                     input bit erdy, input bit [1:0] eov, input int eocc);
    flush_valid = fl;
    in_valid    = iv;
    in_payload  = {p1, p0};
    out_deq_cnt = dq;
    if (fl) exp_q.delete();
    else begin
      if (acc > 0) exp_q.push_back(p0);
      if (acc > 1) exp_q.push_back(p1);
    end
    @(negedge clock);
    chk("in_ready", {31'd0, in_ready}, {31'd0, erdy});
    chk("out_valid", {30'd0, out_valid}, {30'd0, eov});
    chk("occupancy", {{(32-CNT_W){1'b0}}, occupancy}, eocc);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1. reset with garbage inputs
    reset = 1'b1; flush_valid = 1'b1; in_valid = 2'b11;
    in_payload = {32'hDEAD_BEEF, 32'hBAD0_BAD0}; out_deq_cnt = 2'd2;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) cyc(0, 2'b00, 32'h0, 32'h0, 0, 0, 1, 2'b00, 0);

    // 2. single group in, then consume one lane
    cyc(0, 2'b11, 32'hA0, 32'hA1, 0, 2, 1, 2'b00, 0);
    cyc(0, 2'b00, 32'h0,  32'h0,  1, 0, 1, 2'b11, 2);
    cyc(0, 2'b00, 32'h0,  32'h0,  1, 0, 1, 2'b01, 1);

    // 3. fill to full, ready drops from 7 onward, then enq+deq together
    cyc(0, 2'b11, 32'hB0, 32'hB1, 0, 2, 1, 2'b00, 0);
    cyc(0, 2'b11, 32'hB2, 32'hB3, 0, 2, 1, 2'b11, 2);
    cyc(0, 2'b11, 32'hB4, 32'hB5, 0, 2, 1, 2'b11, 4);
    cyc(0, 2'b11, 32'hB6, 32'hB7, 0, 2, 1, 2'b11, 6);
    cyc(0, 2'b11, 32'hC0, 32'hC1, 0, 0, 0, 2'b11, 8);
    cyc(0, 2'b00, 32'h0,  32'h0,  1, 0, 0, 2'b11, 8);
    cyc(0, 2'b11, 32'hC0, 32'hC1, 0, 0, 0, 2'b11, 7);
    cyc(0, 2'b00, 32'h0,  32'h0,  1, 0, 0, 2'b11, 7);
    cyc(0, 2'b11, 32'hC0, 32'hC1, 2, 2, 1, 2'b11, 6);
    cyc(0, 2'b00, 32'h0,  32'h0,  0, 0, 1, 2'b11, 6);

    // 4. head reaches 7, two-lane read straddles index 7 -> 0
    cyc(0, 2'b00, 32'h0,  32'h0,  1, 0, 1, 2'b11, 6);
    cyc(0, 2'b00, 32'h0,  32'h0,  2, 0, 1, 2'b11, 5);

    // 5. five entries buffered, flush with traffic present
    cyc(0, 2'b11, 32'hD0, 32'hD1, 0, 2, 1, 2'b11, 3);
    cyc(1, 2'b11, 32'hE0, 32'hE1, 2, 0, 0, 2'b00, 5);
    cyc(0, 2'b00, 32'h0,  32'h0,  0, 0, 1, 2'b00, 0);

    // 6. non-contiguous valid is dropped; over-dequeue is clamped
    cyc(0, 2'b10, 32'hF0, 32'hF1, 0, 0, 1, 2'b00, 0);
    cyc(0, 2'b00, 32'h0,  32'h0,  0, 0, 1, 2'b00, 0);
    cyc(0, 2'b01, 32'h60, 32'h61, 0, 1, 1, 2'b00, 0);
    cyc(0, 2'b00, 32'h0,  32'h0,  2, 0, 1, 2'b01, 1);
    cyc(0, 2'b00, 32'h0,  32'h0,  0, 0, 1, 2'b00, 0);
    chk("exp_queue_drained", exp_q.size(), 0);

    // reset mid-operation discards contents and blocks same-cycle traffic
    cyc(0, 2'b11, 32'h70, 32'h71, 0, 2, 1, 2'b00, 0);
    reset = 1'b1; in_valid = 2'b11; in_payload = {32'h81, 32'h80}; out_deq_cnt = 2'd0;
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc(0, 2'b00, 32'h0, 32'h0, 0, 0, 1, 2'b00, 0);
    cyc(0, 2'b00, 32'h0, 32'h0, 0, 0, 1, 2'b00, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
